knn_dist_gen: RTL and testbench

KNN_DIST_GEN -- requirements
Module: knn_dist_gen

---
 rtl/knn_dist_gen.sv | 181 ++++++++++++++++++
 tb/tb_knn_dist_gen.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/knn_dist_gen.sv
// knn_dist_gen: streams datapoints against a latched test point and emits the
// squared Euclidean distance of each, tagged with its index in the pass.
// Two registered pipeline stages: difference, then sum of squares.
// Optional build macro KNN_DIST_SAT_EN: saturate dist_entry to all-ones when
// the full sum does not fit in DATA_W bits (default build wraps instead).
//
// Handshake: a datapoint transfers on a rising edge where pt_valid and
// pt_ready are both high; pt_ready does not depend on pt_valid. The output
// side has no back-pressure: valid is a one-cycle qualifier for datap_id and
// dist_entry, which hold their last values while valid is low.
module knn_dist_gen #(
  parameter int DATA_W  = 32,
  parameter int COORD_W = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [7:0]                n_points,
  input  logic signed [COORD_W-1:0] test_x,
  input  logic signed [COORD_W-1:0] test_y,
  input  logic                      pt_valid,
  output logic                      pt_ready,
  input  logic signed [COORD_W-1:0] pt_x,
  input  logic signed [COORD_W-1:0] pt_y,
  output logic                      valid,
  output logic [7:0]                datap_id,
  output logic [DATA_W-1:0]         dist_entry,
  output logic                      busy,
  output logic                      done,
  output logic [1:0]                fsm_state
);

  localparam int DIFF_W = COORD_W + 1;
  localparam int SQ_W   = 2 * COORD_W + 2;
  localparam int SUM_W  = 2 * COORD_W + 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t state, state_next;

  logic [7:0]                n_pts_r;
  logic signed [COORD_W-1:0] test_x_r, test_y_r;
  logic [7:0]                id_cnt;
  logic                      start_ok;
  logic                      accept;

  logic                      s1_valid;
  logic signed [DIFF_W-1:0]  s1_dx, s1_dy;
  logic [7:0]                s1_id;

  logic signed [DIFF_W-1:0]  dx_next, dy_next;
  logic signed [SQ_W-1:0]    sq_x, sq_y;
  logic [SUM_W-1:0]          sum;
  logic [DATA_W-1:0]         dist_next;

  // start is only honoured in IDLE, so the pass parameters stay stable mid-pass
  assign start_ok  = start && (state == S_IDLE);
  assign accept    = pt_valid && (state == S_RUN);
  assign fsm_state = state;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  // Next-state logic and state-decoded outputs
  always_comb begin
    state_next = state;
    pt_ready   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_next = (n_points != 8'd0) ? S_RUN : S_DONE;
      end
      S_RUN: begin
        pt_ready = 1'b1;
        busy     = 1'b1;
        if (pt_valid && (id_cnt == n_pts_r - 8'd1)) state_next = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        // Stage 1 empty means the last result is in (or has left) stage 2
        if (!s1_valid) state_next = S_DONE;
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Pass parameters and id counter, captured on an accepted start
  always_ff @(posedge clk) begin
    if (rst) begin
      n_pts_r  <= 8'd0;
      test_x_r <= '0;
      test_y_r <= '0;
      id_cnt   <= 8'd0;
    end else if (start_ok) begin
      n_pts_r  <= n_points;
      test_x_r <= test_x;
      test_y_r <= test_y;
      id_cnt   <= 8'd0;
    end else if (accept) begin
      id_cnt <= id_cnt + 8'd1;
    end
  end

  // Sign-extended differences; one extra bit makes them exact
  always_comb begin
    dx_next = {pt_x[COORD_W-1], pt_x} - {test_x_r[COORD_W-1], test_x_r};
    dy_next = {pt_y[COORD_W-1], pt_y} - {test_y_r[COORD_W-1], test_y_r};
  end

  // Stage 1: register differences and the point's id
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_dx    <= '0;
      s1_dy    <= '0;
      s1_id    <= 8'd0;
    end else begin
      s1_valid <= accept;
      if (accept) begin
        s1_dx <= dx_next;
        s1_dy <= dy_next;
        s1_id <= id_cnt;
      end
    end
  end

  // Squares are non-negative, so the sum is carried unsigned with one guard bit
  always_comb begin
    sq_x = $signed({{(SQ_W - DIFF_W){s1_dx[DIFF_W-1]}}, s1_dx}) *
           $signed({{(SQ_W - DIFF_W){s1_dx[DIFF_W-1]}}, s1_dx});
    sq_y = $signed({{(SQ_W - DIFF_W){s1_dy[DIFF_W-1]}}, s1_dy}) *
           $signed({{(SQ_W - DIFF_W){s1_dy[DIFF_W-1]}}, s1_dy});
    sum  = {1'b0, sq_x} + {1'b0, sq_y};
  end

`ifdef KNN_DIST_SAT_EN
  localparam int EXT_W = (SUM_W > DATA_W) ? SUM_W : DATA_W;
  logic [EXT_W-1:0] sum_ext;

  // Clamp to all-ones when the sum exceeds the output range
  always_comb begin
    sum_ext   = EXT_W'(sum);
    dist_next = (sum_ext > EXT_W'({DATA_W{1'b1}})) ? {DATA_W{1'b1}}
                                                   : sum_ext[DATA_W-1:0];
  end
`else
  // Keep the low DATA_W bits of the sum
  always_comb begin
    dist_next = DATA_W'(sum);
  end
`endif

  // Stage 2: output register; id and distance only move with a new result
  always_ff @(posedge clk) begin
    if (rst) begin
      valid      <= 1'b0;
      datap_id   <= 8'd0;
      dist_entry <= '0;
    end else begin
      valid <= s1_valid;
      if (s1_valid) begin
        datap_id   <= s1_id;
        dist_entry <= dist_next;
      end
    end
  end

endmodule

// File: tb/tb_knn_dist_gen.sv
// tb_knn_dist_gen: directed vectors for knn_dist_gen. Drivers push the
// expected {result cycle, id, distance} on each accepted point; an
// independent monitor pops and compares whenever valid is seen.
module tb_knn_dist_gen;

  localparam int DATA_W  = 32;
  localparam int COORD_W = 16;
  localparam int EW      = 16 + 8 + DATA_W;

`ifdef KNN_DIST_SAT_EN
  localparam logic [DATA_W-1:0] EXP_OVF = 32'hFFFF_FFFF;
`else
  localparam logic [DATA_W-1:0] EXP_OVF = 32'hFFFC_0002;
`endif

  logic                      clk;
  logic                      rst;
  logic                      start;
  logic [7:0]                n_points;
  logic signed [COORD_W-1:0] test_x, test_y;
  logic                      pt_valid;
  logic                      pt_ready;
  logic signed [COORD_W-1:0] pt_x, pt_y;
  logic                      valid;
  logic [7:0]                datap_id;
  logic [DATA_W-1:0]         dist_entry;
  logic                      busy;
  logic                      done;
  logic [1:0]                fsm_state;

  logic [EW-1:0] exp_q[$];
  int            checks   = 0;
  int            failures = 0;
  int            cyc      = 0;
  logic [7:0]        hold_id;
  logic [DATA_W-1:0] hold_dist;
  bit                hold_known = 0;

  knn_dist_gen #(.DATA_W(DATA_W), .COORD_W(COORD_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .n_points   (n_points),
    .test_x     (test_x),
    .test_y     (test_y),
    .pt_valid   (pt_valid),
    .pt_ready   (pt_ready),
    .pt_x       (pt_x),
    .pt_y       (pt_y),
    .valid      (valid),
    .datap_id   (datap_id),
    .dist_entry (dist_entry),
    .busy       (busy),
    .done       (done),
    .fsm_state  (fsm_state)
  );

  // Clock and cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog cycle=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  // Monitor: compare each result against the scoreboard, and check the hold behaviour
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (rst) begin
      hold_id    = 8'd0;
      hold_dist  = '0;
      hold_known = 1'b1;
    end else if (valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid actual id=%0d dist=0x%0h expected no result cycle=%0d",
                 datap_id, dist_entry, cyc);
      end else begin
        e = exp_q.pop_front();
        check("valid_cycle", 64'(cyc[15:0]), 64'(e[EW-1 -: 16]));
        check("datap_id", 64'(datap_id), 64'(e[DATA_W +: 8]));
        check("dist_entry", 64'(dist_entry), 64'(e[DATA_W-1:0]));
        hold_id   = e[DATA_W +: 8];
        hold_dist = e[DATA_W-1:0];
      end
    end else if (hold_known) begin
      check("hold_id", 64'(datap_id), 64'(hold_id));
      check("hold_dist", 64'(dist_entry), 64'(hold_dist));
    end
  end

  // Driver: pulse start for one cycle; returns the cycle start was high
  task automatic do_start(input logic [7:0] n, input logic signed [15:0] tx,
                          input logic signed [15:0] ty, output int sc);
    start    = 1'b1;
    n_points = n;
    test_x   = tx;
    test_y   = ty;
    sc       = cyc;
    @(posedge clk); #1;
    start    = 1'b0;
  endtask

  // Driver: offer one point until accepted; records the expected result
  task automatic send_pt(input logic signed [15:0] x, input logic signed [15:0] y,
                         input logic [7:0] id, input logic [DATA_W-1:0] d,
                         output int acc);
    pt_valid = 1'b1;
    pt_x     = x;
    pt_y     = y;
    acc      = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (pt_ready) begin
        acc = cyc;
        exp_q.push_back({16'(cyc + 2), id, d});
        break;
      end
    end
    if (acc < 0) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout actual=no pt_ready expected=accept id=%0d", id);
    end
    @(posedge clk); #1;
  endtask

  // Wait (bounded) for the done pulse and check its cycle
  task automatic wait_done(input string name, input int exp_c);
    bit found = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) begin
        check(name, 64'(cyc), 64'(exp_c));
        found = 1;
        break;
      end
    end
    if (!found) begin
      checks++;
      failures++;
      $display("FAIL %s actual=no done expected=done at cycle %0d", name, exp_c);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Directed stimulus
  initial begin
    int sc, t, a0, a1, a2;
    rst = 1'b1; start = 1'b0; n_points = 8'd0; test_x = '0; test_y = '0;
    pt_valid = 1'b0; pt_x = '0; pt_y = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_pt_ready", 64'(pt_ready), 64'd0);
    check("rst_valid", 64'(valid), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_id", 64'(datap_id), 64'd0);
    check("rst_dist", 64'(dist_entry), 64'd0);
    check("rst_state", 64'(fsm_state), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(1);

    // Single point (3,4) against origin
    do_start(8'd1, 16'sd0, 16'sd0, sc);
    send_pt(16'sd3, 16'sd4, 8'd0, 32'd25, t);
    pt_valid = 1'b0;
    check("t1_accept_cycle", 64'(t), 64'(sc + 1));
    wait_done("t1_done", t + 3);
    idle(2);

    // Three back-to-back points
    do_start(8'd3, 16'sd1, 16'sd1, sc);
    send_pt(16'sd1, 16'sd1, 8'd0, 32'd0, a0);
    send_pt(-16'sd2, 16'sd5, 8'd1, 32'd25, a1);
    send_pt(16'sd4, 16'sd1, 8'd2, 32'd9, a2);
    pt_valid = 1'b0;
    @(negedge clk);
    check("t2_ready_low", 64'(pt_ready), 64'd0);
    check("t2_busy_drain", 64'(busy), 64'd1);
    check("t2_back_to_back", 64'(a2), 64'(a0 + 2));
    wait_done("t2_done", a2 + 3);
    idle(2);

    // Extreme coordinates: overflow of the 32-bit output
    do_start(8'd1, -16'sd32768, -16'sd32768, sc);
    send_pt(16'sd32767, 16'sd32767, 8'd0, EXP_OVF, t);
    pt_valid = 1'b0;
    wait_done("t3_done", t + 3);
    idle(2);

    // Empty pass: done next cycle, no point taken even if offered
    do_start(8'd0, 16'sd5, 16'sd5, sc);
    pt_valid = 1'b1;
    @(negedge clk);
    check("t4_done_pulse", 64'(done), 64'd1);
    check("t4_ready", 64'(pt_ready), 64'd0);
    @(negedge clk);
    check("t4_done_clear", 64'(done), 64'd0);
    check("t4_ready_idle", 64'(pt_ready), 64'd0);
    check("t4_state_idle", 64'(fsm_state), 64'd0);
    @(posedge clk); #1;
    pt_valid = 1'b0;
    idle(1);

    // Reset mid-pass after two accepts, then a fresh pass
    do_start(8'd4, 16'sd0, 16'sd0, sc);
    send_pt(16'sd1, 16'sd0, 8'd0, 32'd1, a0);
    send_pt(16'sd0, 16'sd2, 8'd1, 32'd4, a1);
    pt_valid = 1'b0;
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t5_state_idle", 64'(fsm_state), 64'd0);
      check("t5_valid_low", 64'(valid), 64'd0);
    end
    @(posedge clk); #1;
    do_start(8'd2, 16'sd10, 16'sd10, sc);
    send_pt(16'sd13, 16'sd14, 8'd0, 32'd25, a0);
    send_pt(16'sd10, 16'sd10, 8'd1, 32'd0, a1);
    pt_valid = 1'b0;
    wait_done("t5_done", a1 + 3);
    idle(2);

    // start during RUN with another test point is ignored; gap in pt_valid
    do_start(8'd3, 16'sd0, 16'sd0, sc);
    send_pt(-16'sd5, 16'sd12, 8'd0, 32'd169, a0);
    start = 1'b1; n_points = 8'd1; test_x = 16'sd100; test_y = 16'sd100;
    send_pt(16'sd6, 16'sd8, 8'd1, 32'd100, a1);
    start = 1'b0;
    pt_valid = 1'b0;
    idle(1);
    send_pt(-16'sd1, -16'sd1, 8'd2, 32'd2, a2);
    pt_valid = 1'b0;
    check("t6_gap", 64'(a2), 64'(a1 + 2));
    wait_done("t6_done", a2 + 3);
    idle(3);

    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
